// File: rtl/rtttl_tone_gen.sv
`default_nettype none
// ============================================================================
// Module      : rtttl_tone_gen
// Description : Square-wave tone generator for RTTTL playback.
//               The sequencer supplies an (octave, note) pair. The generator
//               drives a buzzer pin with a square wave whose half-period comes
//               from a 12-entry octave-4 table, shifted for the requested
//               octave. A new pitch is taken only at a period boundary, so the
//               output never glitches. A rest or an invalid request mutes the
//               output at the next edge.
//
//               Optional feature macro: RTTTL_TONE_VOLUME_EN
//                 When defined, a volume[1:0] input sets the duty cycle.
//                 The high phase lasts half>>(3-volume) cycles (at least 1).
//                 The period is unchanged.
//
// Ports       : clk      in   1  system clock, 1 MHz
//               rstn     in   1  synchronous active-low reset
//               en       in   1  tone enable; 0 forces mute
//               octave   in   4  requested octave, valid 3..7
//               note     in   4  0 = rest, 1..12 = C..B, 13..15 invalid
//               volume   in   2  duty control (only with RTTTL_TONE_VOLUME_EN)
//               tone_out out  1  square-wave audio
//               active   out  1  1 while a tone is being generated
//
// Revision    : 1.0  initial release
// ============================================================================
module rtttl_tone_gen #(
    parameter int CNT_W = 13
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       en,
    input  logic [3:0] octave,
    input  logic [3:0] note,
`ifdef RTTTL_TONE_VOLUME_EN
    input  logic [1:0] volume,
`endif
    output logic       tone_out,
    output logic       active
);

    typedef enum logic {
        S_MUTE = 1'b0,
        S_PLAY = 1'b1
    } state_t;

    state_t           state_q;
    logic             tone_q;
    logic             active_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       oct_q;
    logic [3:0]       note_q;

    // Half-period in clk cycles. Octave 4 comes straight from the table.
    // Octave 3 doubles it, and octaves 5..7 halve it once per octave, truncating.
    function automatic logic [CNT_W-1:0] half_of(input logic [3:0] oct,
                                                 input logic [3:0] nt);
        logic [11:0]      base;
        logic [CNT_W-1:0] b;
        case (nt)
            4'd1:    base = 12'd1911;
            4'd2:    base = 12'd1804;
            4'd3:    base = 12'd1703;
            4'd4:    base = 12'd1607;
            4'd5:    base = 12'd1517;
            4'd6:    base = 12'd1432;
            4'd7:    base = 12'd1351;
            4'd8:    base = 12'd1276;
            4'd9:    base = 12'd1204;
            4'd10:   base = 12'd1136;
            4'd11:   base = 12'd1073;
            4'd12:   base = 12'd1012;
            default: base = 12'd0;
        endcase
        b = CNT_W'(base);
        if (oct == 4'd3) begin
            half_of = b << 1;
        end else begin
            half_of = b >> (oct - 4'd4);
        end
    endfunction

    logic             w_valid;
    logic [CNT_W-1:0] w_req_half;
    logic [CNT_W-1:0] w_lat_half;
    logic [CNT_W-1:0] w_req_hi;   // high-phase length for a fresh load
    logic [CNT_W-1:0] w_lat_lo;   // low-phase length of the latched pitch

    assign w_valid    = en && (note >= 4'd1) && (note <= 4'd12) &&
                        (octave >= 4'd3) && (octave <= 4'd7);
    assign w_req_half = half_of(octave, note);
    assign w_lat_half = half_of(oct_q, note_q);

`ifdef RTTTL_TONE_VOLUME_EN
    logic [1:0] vol_q;

    function automatic logic [CNT_W-1:0] hi_of(input logic [CNT_W-1:0] half,
                                               input logic [1:0]       vol);
        logic [CNT_W-1:0] h;
        h = half >> (2'd3 - vol);
        hi_of = (h == '0) ? CNT_W'(1) : h;
    endfunction

    assign w_req_hi = hi_of(w_req_half, volume);
    // The low phase absorbs whatever the high phase gave up, so the period
    // stays at 2*half.
    assign w_lat_lo = (w_lat_half << 1) - hi_of(w_lat_half, vol_q);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            vol_q <= 2'd0;
        end else if (w_valid && ((state_q == S_MUTE) ||
                                 (cnt_q == '0 && !tone_q))) begin
            vol_q <= volume;
        end
    end
`else
    assign w_req_hi = w_req_half;
    assign w_lat_lo = w_lat_half;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= S_MUTE;
            tone_q   <= 1'b0;
            active_q <= 1'b0;
            cnt_q    <= '0;
            oct_q    <= 4'd0;
            note_q   <= 4'd0;
        end else begin
            case (state_q)
                S_MUTE: begin
                    tone_q   <= 1'b0;
                    active_q <= 1'b0;
                    cnt_q    <= '0;
                    if (w_valid) begin
                        state_q  <= S_PLAY;
                        tone_q   <= 1'b1;
                        active_q <= 1'b1;
                        cnt_q    <= w_req_hi - CNT_W'(1);
                        oct_q    <= octave;
                        note_q   <= note;
                    end
                end
                S_PLAY: begin
                    if (!w_valid) begin
                        // Mute wins over any position within the period.
                        state_q  <= S_MUTE;
                        tone_q   <= 1'b0;
                        active_q <= 1'b0;
                        cnt_q    <= '0;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else if (tone_q) begin
                        // End of the high phase. The low phase keeps the old pitch.
                        tone_q <= 1'b0;
                        cnt_q  <= w_lat_lo - CNT_W'(1);
                    end else begin
                        // Period boundary. This is the only point where a new pitch is taken.
                        tone_q <= 1'b1;
                        cnt_q  <= w_req_hi - CNT_W'(1);
                        oct_q  <= octave;
                        note_q <= note;
                    end
                end
                default: begin
                    state_q  <= S_MUTE;
                    tone_q   <= 1'b0;
                    active_q <= 1'b0;
                    cnt_q    <= '0;
                end
            endcase
        end
    end

    assign tone_out = tone_q;
    assign active   = active_q;

endmodule
`default_nettype wire

// File: tb/tb_rtttl_tone_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_rtttl_tone_gen
// Description : Self-checking bench for rtttl_tone_gen. Directed scenarios
//               compare measured phase lengths against hand-computed
//               half-periods.
// Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_rtttl_tone_gen;

    logic       clk = 1'b0;
    logic       rstn;
    logic       en;
    logic [3:0] octave;
    logic [3:0] note;
    logic [1:0] volume;
    logic       tone_out;
    logic       active;

    int checks = 0;
    int errors = 0;

    always #500 clk = ~clk;

    rtttl_tone_gen #(.CNT_W(13)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .en       (en),
        .octave   (octave),
        .note     (note),
`ifdef RTTTL_TONE_VOLUME_EN
        .volume   (volume),
`endif
        .tone_out (tone_out),
        .active   (active)
    );

    // Counts consecutive negedge samples at level lvl, including the current one.
    // The count is bounded, so a stuck output shows up as a wrong length.
    task automatic count_level(input logic lvl, output int n);
        n = 0;
        while (tone_out === lvl && n < 10000) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Mutes for two cycles, then requests a pitch. The task returns on the
    // first high cycle.
    task automatic start_tone(input logic [3:0] oct, input logic [3:0] nt);
        en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        en = 1'b1; octave = oct; note = nt;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0; en = 1'b1; octave = 4'd4; note = 4'd10; volume = 2'd3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (tone_out !== 1'b0 || active !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold cyc%0d: tone_out=%b active=%b expected 0/0", i, tone_out, active);
            end
        end
        rstn = 1'b1;
        @(negedge clk);
        checks++;
        if (tone_out !== 1'b1 || active !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: tone_out=%b active=%b expected 1/1", tone_out, active);
        end
    endtask

    // Runs straight on from test_reset, which leaves A4 on its first high cycle.
    task automatic test_steady_a4();
        int n;
        count_level(1'b1, n);
        checks++;
        if (n !== 1136) begin errors++; $display("FAIL a4_high: got %0d expected 1136", n); end
        checks++;
        if (active !== 1'b1) begin errors++; $display("FAIL a4_active: got %b expected 1", active); end
        count_level(1'b0, n);
        checks++;
        if (n !== 1136) begin errors++; $display("FAIL a4_low: got %0d expected 1136", n); end
        count_level(1'b1, n);
        checks++;
        if (n !== 1136) begin errors++; $display("FAIL a4_high2: got %0d expected 1136", n); end
    endtask

    task automatic test_octave_extremes();
        int n;
        start_tone(4'd7, 4'd1);
        count_level(1'b1, n);
        checks++;
        if (n !== 238) begin errors++; $display("FAIL o7c_high: got %0d expected 238", n); end
        count_level(1'b0, n);
        checks++;
        if (n !== 238) begin errors++; $display("FAIL o7c_low: got %0d expected 238", n); end
        start_tone(4'd3, 4'd12);
        count_level(1'b1, n);
        checks++;
        if (n !== 2024) begin errors++; $display("FAIL o3b_high: got %0d expected 2024", n); end
        count_level(1'b0, n);
        checks++;
        if (n !== 2024) begin errors++; $display("FAIL o3b_low: got %0d expected 2024", n); end
    endtask

    task automatic test_glitch_free_change();
        int n;
        start_tone(4'd4, 4'd10);
        repeat (500) @(negedge clk);
        octave = 4'd5; note = 4'd5;
        count_level(1'b1, n);
        checks++;
        if (n !== 636) begin errors++; $display("FAIL chg_old_high: got %0d expected 636", n); end
        count_level(1'b0, n);
        checks++;
        if (n !== 1136) begin errors++; $display("FAIL chg_old_low: got %0d expected 1136", n); end
        count_level(1'b1, n);
        checks++;
        if (n !== 758) begin errors++; $display("FAIL chg_new_high: got %0d expected 758", n); end
        count_level(1'b0, n);
        checks++;
        if (n !== 758) begin errors++; $display("FAIL chg_new_low: got %0d expected 758", n); end
    endtask

    task automatic test_mute_paths();
        int n;
        for (int k = 0; k < 3; k++) begin
            start_tone(4'd4, 4'd10);
            repeat (200) @(negedge clk);
            case (k)
                0:       note = 4'd0;
                1:       begin octave = 4'd8; note = 4'd13; end
                default: en = 1'b0;
            endcase
            @(negedge clk);
            checks++;
            if (tone_out !== 1'b0 || active !== 1'b0) begin
                errors++;
                $display("FAIL mute%0d: tone_out=%b active=%b expected 0/0", k, tone_out, active);
            end
            en = 1'b1; octave = 4'd4; note = 4'd10;
            @(negedge clk);
            checks++;
            if (tone_out !== 1'b1 || active !== 1'b1) begin
                errors++;
                $display("FAIL restore%0d: tone_out=%b active=%b expected 1/1", k, tone_out, active);
            end
            count_level(1'b1, n);
            checks++;
            if (n !== 1136) begin errors++; $display("FAIL restore_high%0d: got %0d expected 1136", k, n); end
        end
    endtask

    task automatic test_reset_mid_tone();
        start_tone(4'd4, 4'd10);
        repeat (50) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        checks++;
        if (tone_out !== 1'b0 || active !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: tone_out=%b active=%b expected 0/0", tone_out, active);
        end
        rstn = 1'b1;
        @(negedge clk);
        checks++;
        if (tone_out !== 1'b1) begin errors++; $display("FAIL reset_mid_restart: got %b expected 1", tone_out); end
    endtask

`ifdef RTTTL_TONE_VOLUME_EN
    task automatic test_volume();
        int n;
        volume = 2'd1;
        start_tone(4'd4, 4'd10);
        count_level(1'b1, n);
        checks++;
        if (n !== 284) begin errors++; $display("FAIL vol1_high: got %0d expected 284", n); end
        count_level(1'b0, n);
        checks++;
        if (n !== 1988) begin errors++; $display("FAIL vol1_low: got %0d expected 1988", n); end
        volume = 2'd3;
        start_tone(4'd4, 4'd10);
        count_level(1'b1, n);
        checks++;
        if (n !== 1136) begin errors++; $display("FAIL vol3_high: got %0d expected 1136", n); end
        count_level(1'b0, n);
        checks++;
        if (n !== 1136) begin errors++; $display("FAIL vol3_low: got %0d expected 1136", n); end
    endtask
`endif

    initial begin
        test_reset();
        test_steady_a4();
        test_octave_extremes();
        test_glitch_free_change();
        test_mute_paths();
        test_reset_mid_tone();
`ifdef RTTTL_TONE_VOLUME_EN
        test_volume();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
